// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: ps2/joystick decode to active-low button vectors plus coin/gap/start sequencer.
// Define ARCADE_INPUT_JOY_FIRE_EN to also drive fire/bomb from joystick bits 6/7.
module arcade_input_mapper #(
  parameter int COIN_CYC  = 2000000,
  parameter int GAP_CYC   = 4000000,
  parameter int START_CYC = 2000000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  output logic [1:0]  but_coin_s,
  output logic [1:0]  but_fire_s,
  output logic [1:0]  but_bomb_s,
  output logic [1:0]  but_select_s,
  output logic [1:0]  but_up_s,
  output logic [1:0]  but_down_s,
  output logic [1:0]  but_left_s,
  output logic [1:0]  but_right_s,
  output logic        seq_busy
);
  localparam int MAXC = (COIN_CYC > GAP_CYC) ? ((COIN_CYC > START_CYC) ? COIN_CYC : START_CYC)
                                             : ((GAP_CYC > START_CYC) ? GAP_CYC : START_CYC);
  localparam int CW = $clog2(MAXC) + 1;
  localparam int K_U1 = 0, K_D1 = 1, K_L1 = 2, K_R1 = 3, K_FI1 = 4, K_BO1 = 5, K_F1 = 6, K_1 = 7,
                 K_F2 = 8, K_2 = 9, K_5 = 10, K_6 = 11, K_U2 = 12, K_D2 = 13, K_L2 = 14, K_R2 = 15,
                 K_FI2 = 16, K_BO2 = 17;
  typedef enum logic [1:0] {IDLE, COIN, GAP, START} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, lim;
  logic [17:0] held_q, held_d, hit;
  logic [1:0] req_q, req, rise, jfire, jbomb;
  logic tog_q, plr_q, plr_d, ev, last;
  logic [15:0] joy;
  logic [8:0] code;
  logic unused_bits;
  assign unused_bits = ^{joystick_0[15:6], joystick_1[15:6]};
  assign code = ps2_key[8:0];
  assign joy = joystick_0 | joystick_1;
  assign ev = ps2_key[10] != tog_q;
`ifdef ARCADE_INPUT_JOY_FIRE_EN
  assign jfire = {joystick_1[6], joystick_0[6]};
  assign jbomb = {joystick_1[7], joystick_0[7]};
`else
  assign jfire = 2'b00;
  assign jbomb = 2'b00;
`endif
  // Arrow keys ignore the E0 prefix bit; everything else matches the full 9-bit code.
  always_comb begin
    hit = '0;
    hit[K_U1]  = code[7:0] == 8'h75;
    hit[K_D1]  = code[7:0] == 8'h72;
    hit[K_L1]  = code[7:0] == 8'h6B;
    hit[K_R1]  = code[7:0] == 8'h74;
    hit[K_FI1] = code == 9'h014;
    hit[K_BO1] = code == 9'h029;
    hit[K_F1]  = code == 9'h005;
    hit[K_1]   = code == 9'h016;
    hit[K_F2]  = code == 9'h006;
    hit[K_2]   = code == 9'h01E;
    hit[K_5]   = code == 9'h02E;
    hit[K_6]   = code == 9'h036;
    hit[K_U2]  = code == 9'h02D;
    hit[K_D2]  = code == 9'h02B;
    hit[K_L2]  = code == 9'h023;
    hit[K_R2]  = code == 9'h034;
    hit[K_FI2] = code == 9'h01C;
    hit[K_BO2] = code == 9'h01B;
    held_d = ev ? ((held_q & ~hit) | (hit & {18{ps2_key[9]}})) : held_q;
  end
  assign req = {held_q[K_F2] | joy[5], held_q[K_F1] | joy[4]};
  assign rise = req & ~req_q;
  assign lim = (state_q == COIN) ? CW'(COIN_CYC) : (state_q == GAP) ? CW'(GAP_CYC) : CW'(START_CYC);
  assign last = cnt_q == lim - CW'(1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    plr_d = plr_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|rise) begin
          state_d = COIN;
          plr_d = ~rise[0];
        end
      end
      COIN:  if (last) begin state_d = GAP;   cnt_d = '0; end
      GAP:   if (last) begin state_d = START; cnt_d = '0; end
      default: if (last) begin state_d = IDLE; cnt_d = '0; end
    endcase
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      plr_q <= 1'b0;
      held_q <= '0;
      req_q <= 2'b00;
      tog_q <= ps2_key[10];
      but_coin_s <= 2'b11;
      but_fire_s <= 2'b11;
      but_bomb_s <= 2'b11;
      but_select_s <= 2'b11;
      but_up_s <= 2'b11;
      but_down_s <= 2'b11;
      but_left_s <= 2'b11;
      but_right_s <= 2'b11;
      seq_busy <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      plr_q <= plr_d;
      held_q <= held_d;
      req_q <= req;
      tog_q <= ps2_key[10];
      but_coin_s <= {1'b1, ~(held_q[K_5] | held_q[K_6] | (state_q == COIN))};
      but_fire_s <= ~({held_q[K_FI2], held_q[K_FI1]} | jfire);
      but_bomb_s <= ~({held_q[K_BO2], held_q[K_BO1]} | jbomb);
      but_select_s <= ~{held_q[K_2] | ((state_q == START) & plr_q),
                        held_q[K_1] | ((state_q == START) & ~plr_q)};
      but_up_s <= ~{held_q[K_U2] | joystick_1[3], held_q[K_U1] | joy[3]};
      but_down_s <= ~{held_q[K_D2] | joystick_1[2], held_q[K_D1] | joy[2]};
      but_left_s <= ~{held_q[K_L2] | joystick_1[1], held_q[K_L1] | joy[1]};
      but_right_s <= ~{held_q[K_R2] | joystick_1[0], held_q[K_R1] | joy[0]};
      seq_busy <= state_q != IDLE;
    end
  end
endmodule
